stage_3_renorm_fifo: RTL and testbench

- Registered successor to the combinational renormalisation stage of the AV1 arithmetic encoder.
- Holds `low` and the bit counter `s` as internal state, applies the per-symbol low update and renormalisation, and serialises the 0..2 pre-bitstream words per symbol into an output FIFO.
- Has valid/ready handshakes on both sides and an end-of-frame FLUSH that emits the final words, the equivalent of od_ec_enc_done.
- Feeds the carry-propagation stage.

---
 rtl/stage_3_renorm_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_stage_3_renorm_fifo.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_3_renorm_fifo.sv
// stage_3_renorm_fifo: registered renormalisation stage of the AV1 arithmetic encoder.
// Holds low/s, applies the per-symbol low update and renormalisation, and queues the
// 0..2 pre-bitstream words per symbol into a first-word-fall-through FIFO. A flush
// request emits the final words of the frame (od_ec_enc_done equivalent).
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o  symbol update handshake
//   bool_symbol_i          [1] bool flag, [0] symbol lsb
//   in_range_i             range before update
//   range_ready_i          renormalised range, registered onto out_range_o at accept
//   d_i                    normalisation shift
//   comp_mux_1_i, u_i      non-bool low-update select and u
//   v_bool_i               bool v
//   flush_i                end-of-frame request (one-cycle pulse)
//   out_valid_o/out_ready_i  FIFO head handshake
//   out_bit_o, out_last_o  FIFO head word and final-word-of-flush flag
//   out_range_o            range of the last accepted update
//   done_o                 one-cycle pulse when a flush has fully drained
module stage_3_renorm_fifo #(
  parameter int unsigned RangeWidth = 16,
  parameter int unsigned LowWidth   = 24,
  parameter int unsigned DSize      = 5,
  parameter int unsigned BitWidth   = 16,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            bool_symbol_i,
  input  logic [RangeWidth-1:0] in_range_i,
  input  logic [RangeWidth-1:0] range_ready_i,
  input  logic [DSize-1:0]      d_i,
  input  logic                  comp_mux_1_i,
  input  logic [RangeWidth:0]   u_i,
  input  logic [RangeWidth:0]   v_bool_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BitWidth-1:0]   out_bit_o,
  output logic                  out_last_o,
  output logic [RangeWidth-1:0] out_range_o,
  output logic                  done_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  // One spare bit so low + m cannot wrap before the flush words are cut out.
  localparam int unsigned EW   = LowWidth + 1;

  localparam logic [EW-1:0] FlushM   = EW'((1 << (RangeWidth - 2)) - 1);
  localparam logic [EW-1:0] FlushBit = EW'(1) << (RangeWidth - 2);
  localparam logic [DSize:0] FsOne   = (DSize + 1)'(1);
  localparam logic [DSize:0] FsStep  = (DSize + 1)'(8);
  localparam logic [PtrW:0] CntFull    = (PtrW + 1)'(FifoDepth);
  localparam logic [PtrW:0] CntHiWater = (PtrW + 1)'(FifoDepth - 2);

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e                state_q, state_d;
  logic [LowWidth-1:0]   low_q, low_d;
  logic [DSize-1:0]      s_q, s_d;
  logic [EW-1:0]         e_q, e_d;
  logic [DSize-1:0]      fc_q, fc_d;
  // Flush bit budget, two's complement; the sign bit marks exhaustion.
  logic [DSize:0]        fs_q, fs_d;
  logic [RangeWidth-1:0] range_q, range_d;
  logic                  done_q, done_d;

  logic [BitWidth:0]     mem_q [FifoDepth];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [PtrW:0]         count_q;
  logic [BitWidth-1:0]   last_word_q;

  logic                  accept, pop;
  logic                  push0_en, push1_en;
  logic [BitWidth:0]     push0_data, push1_data, head;
  logic [PtrW:0]         push_cnt;

  logic                  add_sel;
  logic [RangeWidth-1:0] sub_val, diff;
  logic [LowWidth-1:0]   lp, mask_hi, mask_lo, low_upd, low_f;
  logic [DSize-1:0]      sc, sh_hi, sh_lo, s_upd, s_f, sh_f;
  logic [1:0]            n_words;
  logic [BitWidth-1:0]   word_hi, word_lo;
  logic [DSize:0]        fs_next;
  logic                  fs_done;

  logic unused_msb;
  assign unused_msb = u_i[RangeWidth] ^ v_bool_i[RangeWidth];

  assign in_ready_o  = (state_q == StRun) && (count_q <= CntHiWater);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign head        = mem_q[rptr_q];
  assign out_bit_o   = out_valid_o ? head[BitWidth-1:0] : last_word_q;
  assign out_last_o  = out_valid_o & head[BitWidth];
  assign out_range_o = range_q;
  assign done_o      = done_q;

  // Per-symbol low update and renormalisation.
  always_comb begin
    if (bool_symbol_i[1]) begin
      add_sel = bool_symbol_i[0];
      sub_val = v_bool_i[RangeWidth-1:0];
    end else begin
      add_sel = comp_mux_1_i;
      sub_val = u_i[RangeWidth-1:0];
    end
    diff    = in_range_i - sub_val;
    lp      = add_sel ? low_q + LowWidth'(diff) : low_q;
    sc      = s_q + d_i;
    sh_hi   = s_q + DSize'(7);
    sh_lo   = s_q - DSize'(1);
    mask_hi = (LowWidth'(1) << sh_hi) - LowWidth'(1);
    mask_lo = (LowWidth'(1) << sh_lo) - LowWidth'(1);
    if (sc >= DSize'(17)) begin
      n_words = 2'd2;
    end else if (sc >= DSize'(9)) begin
      n_words = 2'd1;
    end else begin
      n_words = 2'd0;
    end
    word_hi = BitWidth'(lp >> sh_hi);
    word_lo = BitWidth'((lp & mask_hi) >> sh_lo);
    case (n_words)
      2'd0:    low_upd = lp << d_i;
      2'd1:    low_upd = (lp & mask_hi) << d_i;
      default: low_upd = (lp & mask_lo) << d_i;
    endcase
    s_upd = sc - DSize'({n_words, 3'b000});
  end

  // Control FSM and next-state for low/s/flush registers.
  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    s_d        = s_q;
    e_d        = e_q;
    fc_d       = fc_q;
    fs_d       = fs_q;
    range_d    = range_q;
    done_d     = 1'b0;
    push0_en   = 1'b0;
    push0_data = '0;
    push1_en   = 1'b0;
    push1_data = '0;
    // A same-cycle update is folded in before the flush snapshot.
    low_f      = accept ? low_upd : low_q;
    s_f        = accept ? s_upd : s_q;
    sh_f       = fc_q + DSize'(7);
    fs_next    = fs_q - FsStep;
    fs_done    = fs_next[DSize] | (fs_next == '0);

    unique case (state_q)
      StRun: begin
        if (accept) begin
          low_d      = low_upd;
          s_d        = s_upd;
          range_d    = range_ready_i;
          push0_en   = (n_words != 2'd0);
          push0_data = {1'b0, word_hi};
          push1_en   = (n_words == 2'd2);
          push1_data = {1'b0, word_lo};
        end
        if (flush_i) begin
          e_d     = (({1'b0, low_f} + FlushM) & ~FlushM) | FlushBit;
          fc_d    = s_f;
          fs_d    = {1'b0, s_f} + FsOne;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (count_q != CntFull) begin
          push0_en   = 1'b1;
          push0_data = {fs_done, BitWidth'(e_q >> sh_f)};
          e_d        = e_q & ((EW'(1) << sh_f) - EW'(1));
          fc_d       = fc_q - DSize'(8);
          fs_d       = fs_next;
          if (fs_done) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (count_q == '0) begin
          low_d   = '0;
          s_d     = '0;
          done_d  = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign push_cnt = (PtrW + 1)'(push0_en) + (PtrW + 1)'(push1_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      low_q   <= '0;
      s_q     <= '0;
      e_q     <= '0;
      fc_q    <= '0;
      fs_q    <= '0;
      range_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      s_q     <= s_d;
      e_q     <= e_d;
      fc_q    <= fc_d;
      fs_q    <= fs_d;
      range_q <= range_d;
      done_q  <= done_d;
    end
  end

  // Output FIFO: up to two pushes and one pop per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      last_word_q <= '0;
    end else begin
      if (push0_en) begin
        mem_q[wptr_q] <= push0_data;
      end
      if (push1_en) begin
        mem_q[wptr_q + PtrW'(1)] <= push1_data;
      end
      wptr_q  <= wptr_q + PtrW'(push_cnt);
      rptr_q  <= rptr_q + PtrW'(pop);
      count_q <= count_q + push_cnt - (PtrW + 1)'(pop);
      if (pop) begin
        last_word_q <= head[BitWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_stage_3_renorm_fifo.sv
// Bench for stage_3_renorm_fifo: directed cases plus randomized updates/flushes.
// Expected words come from an arithmetic reference model and are queued in a
// scoreboard; a monitor pops and compares whenever the DUT hands over a word.
module tb_stage_3_renorm_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  bool_symbol;
  logic [15:0] in_range, range_ready;
  logic [4:0]  d;
  logic        comp_mux_1;
  logic [16:0] u, v_bool;
  logic        flush;
  logic        out_valid, out_ready;
  logic [15:0] out_bit;
  logic        out_last;
  logic [15:0] out_range;
  logic        done;

  always #5 clk = ~clk;

  stage_3_renorm_fifo dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .bool_symbol_i (bool_symbol),
    .in_range_i    (in_range),
    .range_ready_i (range_ready),
    .d_i           (d),
    .comp_mux_1_i  (comp_mux_1),
    .u_i           (u),
    .v_bool_i      (v_bool),
    .flush_i       (flush),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_bit_o     (out_bit),
    .out_last_o    (out_last),
    .out_range_o   (out_range),
    .done_o        (done)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [16:0] sb[$];
  logic [16:0] mon_exp;
  longint      m_low, m_s;
  logic [15:0] exp_range;
  logic [15:0] last_popped;
  int          ready_mode = 1;
  bit          acc;

  logic [1:0]  st_bs;
  logic [15:0] st_rg, st_rr;
  logic [16:0] st_u, st_v;
  logic [4:0]  st_d;
  logic        st_cm;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint p2(input longint k);
    return longint'(1) << k;
  endfunction

  // Reference: low update, renormalisation and word emission in plain arithmetic.
  task automatic model_update();
    longint sub, diff, lp, sc, n, keep;
    bit add;
    if (st_bs[1]) begin
      add = st_bs[0];
      sub = longint'(st_v[15:0]);
    end else begin
      add = st_cm;
      sub = longint'(st_u[15:0]);
    end
    diff = (longint'(st_rg) - sub + 65536) % 65536;
    lp   = add ? (m_low + diff) % p2(24) : m_low;
    sc   = m_s + longint'(st_d);
    n    = (sc >= 17) ? 2 : (sc >= 9) ? 1 : 0;
    if (n >= 1) sb.push_back({1'b0, 16'((lp / p2(m_s + 7)) % 65536)});
    if (n == 2) sb.push_back({1'b0, 16'(((lp % p2(m_s + 7)) / p2(m_s - 1)) % 65536)});
    keep = (n == 0) ? lp : (n == 1) ? lp % p2(m_s + 7) : lp % p2(m_s - 1);
    m_low = (keep * p2(longint'(st_d))) % p2(24);
    m_s   = sc - 8 * n;
    exp_range = st_rr;
  endtask

  task automatic model_flush();
    longint e, fc, fs, w;
    e = ((m_low + 16383) / 16384) * 16384;
    if (((e / 16384) % 2) == 0) e += 16384;
    fc = m_s;
    fs = m_s + 1;
    while (fs > 0) begin
      w  = (e / p2(fc + 7)) % 65536;
      e  = e % p2(fc + 7);
      fc -= 8;
      fs -= 8;
      sb.push_back({(fs <= 0) ? 1'b1 : 1'b0, 16'(w)});
    end
    m_low = 0;
    m_s   = 0;
  endtask

  task automatic set_stim(input logic [1:0] bs, input logic [15:0] rg, input logic [15:0] rr,
                          input logic [4:0] dd, input logic cm, input logic [16:0] uu,
                          input logic [16:0] vv);
    st_bs = bs; st_rg = rg; st_rr = rr; st_d = dd; st_cm = cm; st_u = uu; st_v = vv;
  endtask

  task automatic randomize_stim();
    st_bs = 2'($urandom % 4);
    st_rg = 16'($urandom_range(32768, 65535));
    st_rr = 16'($urandom);
    st_u  = 17'($urandom);
    st_v  = 17'($urandom);
    st_d  = 5'($urandom_range(0, 15));
    st_cm = 1'($urandom % 2);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("in_ready_during_flush", in_ready, done);
      if (done) begin
        seen = 1;
        check("sb_empty_at_done", sb.size(), 0);
        check("out_valid_at_done", out_valid, 0);
        check("out_bit_hold", out_bit, last_popped);
        check("low_after_flush", dut.low_q, 0);
        check("s_after_flush", dut.s_q, 0);
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  // One transaction slot; update waits for in_ready, flush rides the accepting cycle.
  task automatic issue(input bit upd, input bit fl, input bit bp, output bit accd);
    bit did_flush;
    accd = 0;
    did_flush = 0;
    @(posedge clk); #1;
    bool_symbol = st_bs; in_range = st_rg; range_ready = st_rr; d = st_d;
    comp_mux_1 = st_cm; u = st_u; v_bool = st_v; in_valid = upd;
    if (upd) begin
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bp) check("in_ready_vs_occupancy", in_ready, (sb.size() <= 6) ? 1 : 0);
        if (in_ready) begin
          accd = 1;
          break;
        end
        if (bp) break;
      end
      if (!accd && !bp) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
      end
    end else begin
      @(negedge clk);
    end
    if (accd) model_update();
    if (fl && (accd || !upd)) begin
      flush = 1'b1;
      did_flush = 1;
      model_flush();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    if (accd) check("out_range", out_range, exp_range);
    if (did_flush) wait_done();
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = (($urandom % 4) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL fifo_word: got 0x%0h, expected no word", {out_last, out_bit});
      end else begin
        mon_exp = sb.pop_front();
        check("fifo_word", {out_last, out_bit}, mon_exp);
      end
      last_popped = out_bit;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; bool_symbol = '0; in_range = '0;
    range_ready = '0; d = '0; comp_mux_1 = 1'b0; u = '0; v_bool = '0;
    m_low = 0; m_s = 0; exp_range = '0; last_popped = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_range", out_range, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_low", dut.low_q, 0);
    check("rst_s", dut.s_q, 0);
    rst_n = 1'b1;

    set_stim(2'b00, 16'h8000, 16'h1111, 5'd1, 1'b1, 17'h04000, 17'h0);
    issue(1, 0, 0, acc);
    check("t1_low", dut.low_q, 'h8000);
    check("t1_s", dut.s_q, 1);
    set_stim(2'b00, 16'h8000, 16'h2222, 5'd15, 1'b0, 17'h04000, 17'h0);
    issue(1, 0, 0, acc);
    check("t2_low", dut.low_q, 0);
    check("t2_s", dut.s_q, 8);
    repeat (2) @(negedge clk);
    check("t2_word", last_popped, 'h80);
    set_stim(2'b00, 16'hFFFF, 16'h3333, 5'd15, 1'b1, 17'h00001, 17'h0);
    issue(1, 0, 0, acc);
    check("t3_low", dut.low_q, 'h3F0000);
    check("t3_s", dut.s_q, 7);
    repeat (3) @(negedge clk);
    check("t3_last_word", last_popped, 'hFF);
    issue(0, 1, 0, acc);

    set_stim(2'b11, 16'h8000, 16'h4444, 5'd1, 1'b0, 17'h0, 17'h02000);
    issue(1, 0, 0, acc);
    check("bool11_low", dut.low_q, 'hC000);
    check("bool11_s", dut.s_q, 1);
    issue(0, 1, 0, acc);
    set_stim(2'b10, 16'h8000, 16'h5555, 5'd1, 1'b0, 17'h0, 17'h02000);
    issue(1, 0, 0, acc);
    check("bool10_low", dut.low_q, 0);
    check("bool10_s", dut.s_q, 1);
    issue(0, 1, 0, acc);

    issue(0, 1, 0, acc);
    check("flush_zero_word", last_popped, 'h80);

    set_stim(2'b00, 16'h8000, 16'h6666, 5'd8, 1'b0, 17'h0, 17'h0);
    issue(1, 0, 0, acc);
    check("s8_s", dut.s_q, 8);
    issue(0, 1, 0, acc);

    randomize_stim();
    issue(1, 1, 0, acc);

    ready_mode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      randomize_stim();
      issue(1, 0, 1, acc);
      if (!acc) break;
    end
    ready_mode = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("bp_drained", sb.size(), 0);
    issue(0, 1, 0, acc);

    ready_mode = 0;
    repeat (2) @(posedge clk);
    set_stim(2'b00, 16'h8000, 16'h7777, 5'd9, 1'b1, 17'h04000, 17'h0);
    issue(1, 0, 0, acc);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("in_ready_in_flush", in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_range", out_range, 0);
    check("rst2_done", done, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_out_bit", out_bit, 0);
    check("rst2_out_last", out_last, 0);
    sb.delete();
    m_low = 0; m_s = 0; exp_range = '0; last_popped = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    set_stim(2'b00, 16'h8000, 16'h1111, 5'd1, 1'b1, 17'h04000, 17'h0);
    issue(1, 0, 0, acc);
    check("rst2_t1_low", dut.low_q, 'h8000);
    check("rst2_t1_s", dut.s_q, 1);
    repeat (3) @(negedge clk);
    check("rst2_no_word", sb.size(), 0);

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int r;
      randomize_stim();
      r = $urandom % 10;
      if (r < 7) issue(1, 0, 0, acc);
      else if (r == 7) issue(1, 1, 0, acc);
      else if (r == 8) issue(0, 1, 0, acc);
      else issue(0, 0, 0, acc);
    end
    ready_mode = 1;
    issue(0, 1, 0, acc);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
